debug_dump_sequencer: RTL
=========================

Name: debug_dump_sequencer

Overview:
Sequences the post-halt state dump of the pipeline to the host over the UART TX FIFO. On a start pulse from the debugger it walks the debug address through the register file, then through data memory, then captures the PC. Each 32-bit word is serialized into bytes, LSB first, and written to the TX FIFO while honouring TX-full backpressure. It sits between the pipeline debug outputs (register data, memory data, PC, debug address) and the UART write interface.

Parameters:
DATA_SZ, 32, width of register/memory/PC words; must be a multiple of 8
W, 5, debug address width
N_REGS, 32, registers dumped (addresses 0..N_REGS-1), N_REGS <= 2^W
N_MEMS, 32, memory words dumped (addresses 0..N_MEMS-1), N_MEMS <= 2^W

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_start  in  1  dump request pulse, sampled only in IDLE
i_register_data  in  DATA_SZ  register file word at o_addr
i_memory_data  in  DATA_SZ  data memory word at o_addr
i_pc  in  DATA_SZ  current PC
i_tx_full  in  1  UART TX FIFO full
o_wr_uart  out  1  TX FIFO write strobe
o_w_data  out  8  byte to TX FIFO
o_addr  out  W  debug address driven to the pipeline
o_busy  out  1  high from leaving IDLE until DONE inclusive
o_done  out  1  one-cycle pulse when the dump completes

Behaviour:
- One clock (i_clk); reset is synchronous and active-high on i_reset.
- Reset values: state IDLE; o_addr=0; section=REGS; byte counter=0; shift register=0; o_busy=0; o_done=0; o_wr_uart=0; o_w_data=0.
- State machine: IDLE, SET_ADDR, LATCH, SEND, DONE.
- IDLE: when i_start=1, go to SET_ADDR with o_addr=0 and section=REGS. Otherwise stay.
- SET_ADDR: one settle cycle so the datapath read at o_addr is valid. Always go to LATCH.
- LATCH: load the shift register from the current section: REGS uses i_register_data, MEM uses i_memory_data, PC uses i_pc. Clear the byte counter and go to SEND.
- SEND:
  - o_wr_uart = (state==SEND && !i_tx_full), combinational.
  - o_w_data = shift_reg[7:0], combinational in SEND; 0 in other states.
  - On each write, shift right by 8 and increment the byte counter.
  - When i_tx_full=1, hold everything, with no write and no shift.
  - After DATA_SZ/8 writes:
    - REGS, address < N_REGS-1: o_addr+1, go to SET_ADDR.
    - REGS, last address: section=MEM, o_addr=0, go to SET_ADDR.
    - MEM, address < N_MEMS-1: o_addr+1, go to SET_ADDR.
    - MEM, last address: section=PC, o_addr=0, go to SET_ADDR.
    - PC: go to DONE.
- DONE: o_done=1 for one cycle, o_busy=1. Then go to IDLE with o_addr=0 and o_busy=0.
- Latency and volume:
  - Each word takes 2 + DATA_SZ/8 cycles with no backpressure.
  - With defaults, 65 words produce 260 bytes in 390 cycles.
  - DONE occurs in cycle 391 after the start sample.
- i_start while busy is ignored; no queuing.
- i_reset mid-dump returns all state to reset values immediately. The partial dump is abandoned; no further writes occur.
- The byte counter never exceeds DATA_SZ/8. The o_addr increment never wraps, since N_REGS/N_MEMS <= 2^W.

Optional Feature:
DUMP_CHECKSUM_EN:
- Defined: a CHKSUM state is inserted between the PC word and DONE.
  - A running XOR of every byte written is held in an 8-bit register, cleared on start and on reset.
  - CHKSUM writes that XOR as one extra byte, subject to the same i_tx_full rule as SEND, then goes to DONE.
  - With defaults: 261 bytes, 391 cycles to the last write.
- Undefined: no checksum logic; the sequence ends at the last PC byte.

Test Plan:
- Register r=0x0000000r, mem m=0x100+m, pc=0x00000040, i_tx_full=0, pulse i_start -> 260 writes. Byte 0..3 = 00,00,00,00; bytes 4..7 = 01,00,00,00; bytes 128..131 = 00,01,00,00; last 4 = 40,00,00,00. o_done pulses exactly once, 391 cycles after the start sample.
- Same setup, hold i_tx_full=1 for 10 cycles starting at the 3rd byte of word 5 -> no writes during the hold. Byte order is unchanged and the total stays 260; done arrives 10 cycles later.
- Pulse i_start again at cycle 50 of a dump -> ignored; exactly 260 bytes and one o_done.
- Assert i_reset at cycle 100 -> next cycle o_wr_uart=0, o_busy=0, o_addr=0. A new i_start produces a complete dump starting at byte 0.
- o_addr trace: 0..31 in REGS, 0..31 in MEM, 0 for PC. Each value is held for 6 cycles with no backpressure.
- With DUMP_CHECKSUM_EN and all inputs 0xA5A5A5A5 -> 261 bytes, the final byte = 0x00. With regs=1 and all others 0 -> final byte = 0x00 (32 ones XOR to 0). With reg0=1 only -> final byte = 0x01.

Source files
------------

// File: rtl/debug_dump_sequencer.sv
// Post-halt state dump: register file, data memory and PC serialized LSB-first into the UART TX FIFO.
// Define DUMP_CHECKSUM_EN to append one XOR checksum byte after the PC word.
module debug_dump_sequencer #(
    parameter int DATA_SZ = 32,
    parameter int W       = 5,
    parameter int N_REGS  = 32,
    parameter int N_MEMS  = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [DATA_SZ-1:0] i_register_data,
    input  logic [DATA_SZ-1:0] i_memory_data,
    input  logic [DATA_SZ-1:0] i_pc,
    input  logic               i_tx_full,
    output logic               o_wr_uart,
    output logic [7:0]         o_w_data,
    output logic [W-1:0]       o_addr,
    output logic               o_busy,
    output logic               o_done
);

    localparam int NB = DATA_SZ / 8;
    localparam int CW = $clog2(NB + 1);

    typedef enum logic [2:0] {
        IDLE,
        SET_ADDR,
        LATCH,
        SEND,
`ifdef DUMP_CHECKSUM_EN
        CHKSUM,
`endif
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SEC_REGS,
        SEC_MEM,
        SEC_PC
    } section_t;

    state_t             state, state_next;
    section_t           section;
    logic [DATA_SZ-1:0] shift_reg;
    logic [CW-1:0]      byte_cnt;
    logic               word_done;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]         chk;
`endif

    // Last byte of the current word is leaving this cycle.
    assign word_done = (state == SEND) && !i_tx_full && (byte_cnt == CW'(NB - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (i_start) state_next = SET_ADDR;
            SET_ADDR: state_next = LATCH;
            LATCH:    state_next = SEND;
            SEND: begin
                if (word_done) begin
                    if (section == SEC_PC) begin
`ifdef DUMP_CHECKSUM_EN
                        state_next = CHKSUM;
`else
                        state_next = DONE;
`endif
                    end else begin
                        state_next = SET_ADDR;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CHKSUM:   if (!i_tx_full) state_next = DONE;
`endif
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        o_wr_uart = 1'b0;
        o_w_data  = 8'h00;
        o_busy    = (state != IDLE);
        o_done    = (state == DONE);
        case (state)
            SEND: begin
                o_wr_uart = !i_tx_full;
                o_w_data  = shift_reg[7:0];
            end
`ifdef DUMP_CHECKSUM_EN
            CHKSUM: begin
                o_wr_uart = !i_tx_full;
                o_w_data  = chk;
            end
`endif
            default: ;
        endcase
    end

    // Address walk, word capture and byte serialization.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_addr    <= '0;
            section   <= SEC_REGS;
            shift_reg <= '0;
            byte_cnt  <= '0;
`ifdef DUMP_CHECKSUM_EN
            chk       <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_addr  <= '0;
                        section <= SEC_REGS;
`ifdef DUMP_CHECKSUM_EN
                        chk     <= 8'h00;
`endif
                    end
                end
                LATCH: begin
                    case (section)
                        SEC_REGS: shift_reg <= i_register_data;
                        SEC_MEM:  shift_reg <= i_memory_data;
                        default:  shift_reg <= i_pc;
                    endcase
                    byte_cnt <= '0;
                end
                SEND: begin
                    if (!i_tx_full) begin
                        shift_reg <= shift_reg >> 8;
                        byte_cnt  <= byte_cnt + CW'(1);
`ifdef DUMP_CHECKSUM_EN
                        chk       <= chk ^ shift_reg[7:0];
`endif
                    end
                    if (word_done) begin
                        case (section)
                            SEC_REGS: begin
                                if (o_addr == W'(N_REGS - 1)) begin
                                    section <= SEC_MEM;
                                    o_addr  <= '0;
                                end else begin
                                    o_addr <= o_addr + W'(1);
                                end
                            end
                            SEC_MEM: begin
                                if (o_addr == W'(N_MEMS - 1)) begin
                                    section <= SEC_PC;
                                    o_addr  <= '0;
                                end else begin
                                    o_addr <= o_addr + W'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                DONE:    o_addr <= '0;
                default: ;
            endcase
        end
    end

endmodule
